// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Purpose  : Decode-to-execute stage. Decodes a MIPS instruction into an ALU
//            opcode and operands, detects load-use hazards against the
//            instruction currently in E, and owns the ID/EX pipeline register
//            (stall, flush, bubble insertion).
// Ports    : clk, rst           - clock / synchronous active-high reset
//            validD, instrD, pcD - decode-side instruction and its PC
//            rsDataD, rtDataD    - forwarded register operands
//            stallE, flushE      - downstream hold / bubble requests
//            readyD              - decode may advance this cycle
//            loadUseStall        - combinational load-use hazard flag
//            validE .. pcE       - registered execute-stage contents
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
  parameter int WORD_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              validD,
  input  logic [31:0]       instrD,
  input  logic [31:0]       pcD,
  input  logic [WORD_W-1:0] rsDataD,
  input  logic [WORD_W-1:0] rtDataD,
  input  logic              stallE,
  input  logic              flushE,
  output logic              readyD,
  output logic              loadUseStall,
  output logic              validE,
  output logic [OP_W-1:0]   aluOpE,
  output logic [WORD_W-1:0] SrcA,
  output logic [WORD_W-1:0] SrcB,
  output logic [WORD_W-1:0] storeDataE,
  output logic [4:0]        writeRegE,
  output logic              regWriteE,
  output logic              memReadE,
  output logic              memWriteE,
  output logic              illegalE,
  output logic [31:0]       pcE
);

  // ALU opcode encodings shared with the execute stage
  localparam logic [OP_W-1:0] ALU_AND      = OP_W'(0);
  localparam logic [OP_W-1:0] ALU_SUB      = OP_W'(1);
  localparam logic [OP_W-1:0] ALU_ADD      = OP_W'(2);
  localparam logic [OP_W-1:0] ALU_XOR      = OP_W'(3);
  localparam logic [OP_W-1:0] ALU_NOR      = OP_W'(4);
  localparam logic [OP_W-1:0] ALU_OR       = OP_W'(5);
  localparam logic [OP_W-1:0] ALU_EQB      = OP_W'(6);
  localparam logic [OP_W-1:0] ALU_SLT      = OP_W'(7);
  localparam logic [OP_W-1:0] ALU_SLTU     = OP_W'(8);
  localparam logic [OP_W-1:0] ALU_LS_LEFT  = OP_W'(9);
  localparam logic [OP_W-1:0] ALU_LS_RIGHT = OP_W'(10);
  localparam logic [OP_W-1:0] ALU_AS_RIGHT = OP_W'(11);

  // Instruction fields
  logic [5:0]  w_opcode;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
  logic [5:0]  w_funct;
  logic [15:0] w_imm;

  assign w_opcode = instrD[31:26];
  assign w_rs     = instrD[25:21];
  assign w_rt     = instrD[20:16];
  assign w_rd     = instrD[15:11];
  assign w_shamt  = instrD[10:6];
  assign w_funct  = instrD[5:0];
  assign w_imm    = instrD[15:0];

  logic [WORD_W-1:0] w_imm_sx, w_imm_zx, w_shamt_zx, w_imm_hi;
  assign w_imm_sx   = {{(WORD_W-16){w_imm[15]}}, w_imm};
  assign w_imm_zx   = {{(WORD_W-16){1'b0}}, w_imm};
  assign w_shamt_zx = {{(WORD_W-5){1'b0}}, w_shamt};
  assign w_imm_hi   = {w_imm, {(WORD_W-16){1'b0}}};

  // Decoded next-state contents of the E register
  logic [OP_W-1:0]   alu_op_d;
  logic [WORD_W-1:0] src_a_d, src_b_d;
  logic [4:0]        dest_d;
  logic              reg_write_d, mem_read_d, mem_write_d, illegal_d;
  logic              rs_used, rt_used;

  always_comb begin
    alu_op_d    = ALU_ADD;
    src_a_d     = rsDataD;
    src_b_d     = rtDataD;
    dest_d      = 5'd0;
    reg_write_d = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    illegal_d   = 1'b0;
    rs_used     = 1'b1;
    rt_used     = 1'b0;

    if (w_opcode == 6'h00) begin
      rt_used     = 1'b1;
      dest_d      = w_rd;
      reg_write_d = 1'b1;
      case (w_funct)
        6'h20, 6'h21: alu_op_d = ALU_ADD;
        6'h22, 6'h23: alu_op_d = ALU_SUB;
        6'h24:        alu_op_d = ALU_AND;
        6'h25:        alu_op_d = ALU_OR;
        6'h26:        alu_op_d = ALU_XOR;
        6'h27:        alu_op_d = ALU_NOR;
        6'h2A:        alu_op_d = ALU_SLT;
        6'h2B:        alu_op_d = ALU_SLTU;
        // constant shifts take the amount from shamt and ignore rs
        6'h00: begin alu_op_d = ALU_LS_LEFT;  src_a_d = w_shamt_zx; rs_used = 1'b0; end
        6'h02: begin alu_op_d = ALU_LS_RIGHT; src_a_d = w_shamt_zx; rs_used = 1'b0; end
        6'h03: begin alu_op_d = ALU_AS_RIGHT; src_a_d = w_shamt_zx; rs_used = 1'b0; end
        6'h04:        alu_op_d = ALU_LS_LEFT;
        6'h06:        alu_op_d = ALU_LS_RIGHT;
        6'h07:        alu_op_d = ALU_AS_RIGHT;
        default: begin
          illegal_d   = 1'b1;
          reg_write_d = 1'b0;
          dest_d      = 5'd0;
        end
      endcase
    end else begin
      dest_d      = w_rt;
      reg_write_d = 1'b1;
      case (w_opcode)
        6'h08, 6'h09: begin alu_op_d = ALU_ADD;  src_b_d = w_imm_sx; end
        6'h0A:        begin alu_op_d = ALU_SLT;  src_b_d = w_imm_sx; end
        6'h0B:        begin alu_op_d = ALU_SLTU; src_b_d = w_imm_sx; end
        6'h0C:        begin alu_op_d = ALU_AND;  src_b_d = w_imm_zx; end
        6'h0D:        begin alu_op_d = ALU_OR;   src_b_d = w_imm_zx; end
        6'h0E:        begin alu_op_d = ALU_XOR;  src_b_d = w_imm_zx; end
        6'h0F: begin
          alu_op_d = ALU_EQB;
          src_a_d  = w_imm_hi;
          src_b_d  = '0;
          rs_used  = 1'b0;
        end
        6'h23: begin
          alu_op_d   = ALU_ADD;
          src_b_d    = w_imm_sx;
          mem_read_d = 1'b1;
        end
        6'h2B: begin
          alu_op_d    = ALU_ADD;
          src_b_d     = w_imm_sx;
          mem_write_d = 1'b1;
          reg_write_d = 1'b0;
          dest_d      = 5'd0;
          rt_used     = 1'b1;
        end
        default: begin
          illegal_d   = 1'b1;
          reg_write_d = 1'b0;
          dest_d      = 5'd0;
        end
      endcase
    end

    // writes to $0 are architecturally discarded
    if (dest_d == 5'd0) reg_write_d = 1'b0;
  end

  // E register
  logic              valid_q, reg_write_q, mem_read_q, mem_write_q, illegal_q;
  logic [OP_W-1:0]   alu_op_q;
  logic [WORD_W-1:0] src_a_q, src_b_q, store_q;
  logic [4:0]        dest_q;
  logic [31:0]       pc_q;

  // Hazard: the load in E produces a register the D instruction reads
  assign loadUseStall = validD & valid_q & mem_read_q & (dest_q != 5'd0) &
                        ((rs_used & (w_rs == dest_q)) | (rt_used & (w_rt == dest_q)));

  assign readyD = ~rst & ~stallE & ~loadUseStall;

  // Bubble whenever reset/flush, or when advancing without a consumable
  // instruction (hazard or empty D slot). A stall alone holds everything.
  logic w_bubble, w_load;
  assign w_bubble = rst | flushE | (~stallE & (loadUseStall | ~validD));
  assign w_load   = ~stallE;

  always_ff @(posedge clk) begin
    if (w_bubble) begin
      valid_q     <= 1'b0;
      alu_op_q    <= '0;
      src_a_q     <= '0;
      src_b_q     <= '0;
      store_q     <= '0;
      dest_q      <= 5'd0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      illegal_q   <= 1'b0;
      pc_q        <= 32'd0;
    end else if (w_load) begin
      valid_q     <= 1'b1;
      alu_op_q    <= alu_op_d;
      src_a_q     <= src_a_d;
      src_b_q     <= src_b_d;
      store_q     <= rtDataD;
      dest_q      <= dest_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      illegal_q   <= illegal_d;
      pc_q        <= pcD;
    end
  end

  assign validE     = valid_q;
  assign aluOpE     = alu_op_q;
  assign SrcA       = src_a_q;
  assign SrcB       = src_b_q;
  assign storeDataE = store_q;
  assign writeRegE  = dest_q;
  assign regWriteE  = reg_write_q;
  assign memReadE   = mem_read_q;
  assign memWriteE  = mem_write_q;
  assign illegalE   = illegal_q;
  assign pcE        = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Purpose  : Self-checking bench for id_ex_stage. Directed scenarios followed
//            by randomized traffic, compared against an instruction-level
//            reference model of the E slot.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, validD, stallE, flushE;
  logic [31:0] instrD, pcD, rsDataD, rtDataD;
  logic        readyD, loadUseStall, validE;
  logic [3:0]  aluOpE;
  logic [31:0] SrcA, SrcB, storeDataE, pcE;
  logic [4:0]  writeRegE;
  logic        regWriteE, memReadE, memWriteE, illegalE;

  id_ex_stage #(.WORD_W(32), .OP_W(4)) dut (
    .clk(clk), .rst(rst), .validD(validD), .instrD(instrD), .pcD(pcD),
    .rsDataD(rsDataD), .rtDataD(rtDataD), .stallE(stallE), .flushE(flushE),
    .readyD(readyD), .loadUseStall(loadUseStall), .validE(validE),
    .aluOpE(aluOpE), .SrcA(SrcA), .SrcB(SrcB), .storeDataE(storeDataE),
    .writeRegE(writeRegE), .regWriteE(regWriteE), .memReadE(memReadE),
    .memWriteE(memWriteE), .illegalE(illegalE), .pcE(pcE)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Expected E-slot contents plus which fields are defined for it
  typedef struct packed {
    logic        valid, rw, mr, mw, ill;
    logic [3:0]  op;
    logic [31:0] a, b, st, pc;
    logic [4:0]  w;
    logic        chkA, chkB, chkW, chkSt, zero, rsU, rtU;
  } exp_t;

  exp_t m;
  logic m_known = 1'b0;

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                        input int sh, input int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  // Reference: what each MIPS instruction asks the ALU to do
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int op, fn, rt, rd, sh, imm;
    op  = int'(ins[31:26]); fn = int'(ins[5:0]);
    rt  = int'(ins[20:16]); rd = int'(ins[15:11]); sh = int'(ins[10:6]);
    imm = int'(ins[15:0]);
    e = '0;
    e.valid = 1; e.pc = pc; e.chkA = 1; e.chkB = 1; e.chkW = 1; e.rsU = 1;
    if (op == 0) begin
      e.rtU = 1; e.a = a; e.b = b; e.w = 5'(rd); e.rw = 1;
      case (fn)
        'h20, 'h21: e.op = 2;
        'h22, 'h23: e.op = 1;
        'h24: e.op = 0;
        'h25: e.op = 5;
        'h26: e.op = 3;
        'h27: e.op = 4;
        'h2A: e.op = 7;
        'h2B: e.op = 8;
        'h00: begin e.op = 9;  e.a = 32'(sh); e.rsU = 0; end
        'h02: begin e.op = 10; e.a = 32'(sh); e.rsU = 0; end
        'h03: begin e.op = 11; e.a = 32'(sh); e.rsU = 0; end
        'h04: e.op = 9;
        'h06: e.op = 10;
        'h07: e.op = 11;
        default: begin e.op = 2; e.ill = 1; e.rw = 0; e.chkA = 0; e.chkB = 0; e.chkW = 0; end
      endcase
    end else begin
      e.a = a; e.w = 5'(rt); e.rw = 1;
      case (op)
        'h08, 'h09: begin e.op = 2; e.b = 32'($signed(16'(imm))); end
        'h0A:       begin e.op = 7; e.b = 32'($signed(16'(imm))); end
        'h0B:       begin e.op = 8; e.b = 32'($signed(16'(imm))); end
        'h0C:       begin e.op = 0; e.b = 32'(imm); end
        'h0D:       begin e.op = 5; e.b = 32'(imm); end
        'h0E:       begin e.op = 3; e.b = 32'(imm); end
        'h0F:       begin e.op = 6; e.a = 32'(imm) * 65536; e.chkB = 0; e.rsU = 0; end
        'h23:       begin e.op = 2; e.b = 32'($signed(16'(imm))); e.mr = 1; end
        'h2B: begin
          e.op = 2; e.b = 32'($signed(16'(imm))); e.mw = 1; e.rw = 0;
          e.chkW = 0; e.chkSt = 1; e.st = b; e.rtU = 1;
        end
        default: begin e.op = 2; e.ill = 1; e.rw = 0; e.chkA = 0; e.chkB = 0; e.chkW = 0; end
      endcase
    end
    if (e.w == 0) e.rw = 0;
    return e;
  endfunction

  task automatic check_e();
    check("validE", validE, m.valid);
    check("regWriteE", regWriteE, m.rw);
    check("memReadE", memReadE, m.mr);
    check("memWriteE", memWriteE, m.mw);
    check("illegalE", illegalE, m.ill);
    if (m.zero) begin
      check("rst.aluOpE", aluOpE, 0);
      check("rst.SrcA", SrcA, 0);
      check("rst.SrcB", SrcB, 0);
      check("rst.pcE", pcE, 0);
      check("rst.writeRegE", writeRegE, 0);
      check("rst.storeDataE", storeDataE, 0);
    end else if (m.valid) begin
      check("aluOpE", aluOpE, m.op);
      check("pcE", pcE, m.pc);
      if (m.chkW)  check("writeRegE", writeRegE, m.w);
      if (m.chkA)  check("SrcA", SrcA, m.a);
      if (m.chkB)  check("SrcB", SrcB, m.b);
      if (m.chkSt) check("storeDataE", storeDataE, m.st);
    end
  endtask

  // One clock: check combinational outputs, predict, advance, check E
  task automatic cycle();
    exp_t d, n;
    logic lus;
    #1;
    d   = ref_decode(instrD, pcD, rsDataD, rtDataD);
    lus = validD && m.valid && m.mr && (m.w != 0) &&
          ((d.rsU && instrD[25:21] == m.w) || (d.rtU && instrD[20:16] == m.w));
    if (rst) check("readyD.rst", readyD, 0);
    else if (m_known) begin
      check("loadUseStall", loadUseStall, lus);
      check("readyD", readyD, !stallE && !lus);
    end
    if (rst) begin
      n = '0; n.zero = 1;
    end else if (flushE || (!stallE && (lus || !validD))) begin
      n = '0;
    end else if (stallE) begin
      n = m;
    end else begin
      n = d;
    end
    @(posedge clk);
    #1;
    if (rst) m_known = 1;
    m = n;
    if (m_known) check_e();
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] a,
                       input logic [31:0] b, input logic s, input logic f, input logic r);
    validD = v; instrD = ins; rsDataD = a; rtDataD = b;
    stallE = s; flushE = f; rst = r;
    pcD = pcD + 32'd4;
  endtask

  function automatic logic [31:0] rand_instr();
    int k, rs, rt, rd;
    k  = int'($urandom_range(0, 29));
    rs = int'($urandom_range(0, 3)); rt = int'($urandom_range(0, 3)); rd = int'($urandom_range(0, 3));
    case (k)
      0: return rtype(rs, rt, rd, 0, 'h20);   1: return rtype(rs, rt, rd, 0, 'h21);
      2: return rtype(rs, rt, rd, 0, 'h22);   3: return rtype(rs, rt, rd, 0, 'h23);
      4: return rtype(rs, rt, rd, 0, 'h24);   5: return rtype(rs, rt, rd, 0, 'h25);
      6: return rtype(rs, rt, rd, 0, 'h26);   7: return rtype(rs, rt, rd, 0, 'h27);
      8: return rtype(rs, rt, rd, 0, 'h2A);   9: return rtype(rs, rt, rd, 0, 'h2B);
      10: return rtype(rs, rt, rd, int'($urandom_range(0, 31)), 'h00);
      11: return rtype(rs, rt, rd, int'($urandom_range(0, 31)), 'h02);
      12: return rtype(rs, rt, rd, int'($urandom_range(0, 31)), 'h03);
      13: return rtype(rs, rt, rd, 0, 'h04);  14: return rtype(rs, rt, rd, 0, 'h06);
      15: return rtype(rs, rt, rd, 0, 'h07);  16: return rtype(rs, rt, rd, 0, 'h3F);
      17: return itype('h08, rs, rt, int'($urandom));
      18: return itype('h09, rs, rt, int'($urandom));
      19: return itype('h0A, rs, rt, int'($urandom));
      20: return itype('h0B, rs, rt, int'($urandom));
      21: return itype('h0C, rs, rt, int'($urandom));
      22: return itype('h0D, rs, rt, int'($urandom));
      23: return itype('h0E, rs, rt, int'($urandom));
      24: return itype('h0F, rs, rt, int'($urandom));
      25, 26, 27: return itype('h23, rs, rt, int'($urandom));
      28: return itype('h2B, rs, rt, int'($urandom));
      default: return itype('h3F, rs, rt, int'($urandom));
    endcase
  endfunction

  initial begin
    m = '0;
    pcD = 32'h0000_1000;
    drive(0, 0, 0, 0, 0, 0, 1); cycle();
    drive(0, 0, 0, 0, 0, 0, 1); cycle();

    // add $3,$1,$2
    drive(1, rtype(1, 2, 3, 0, 'h20), 5, 7, 0, 0, 0); cycle();
    check("add.aluOpE", aluOpE, 2); check("add.SrcA", SrcA, 5); check("add.SrcB", SrcB, 7);
    check("add.writeRegE", writeRegE, 3); check("add.regWriteE", regWriteE, 1);
    check("add.validE", validE, 1);

    // sra $4,$5,3 and srav
    drive(1, rtype(0, 5, 4, 3, 'h03), 32'hDEAD_BEEF, 32'h8000_0000, 0, 0, 0); cycle();
    check("sra.aluOpE", aluOpE, 11); check("sra.SrcA", SrcA, 3); check("sra.SrcB", SrcB, 32'h8000_0000);
    drive(1, rtype(1, 5, 4, 0, 'h07), 32'h23, 32'h8000_0000, 0, 0, 0); cycle();
    check("srav.SrcA", SrcA, 32'h23);

    // immediate extension
    drive(1, itype('h08, 1, 2, 'hFFFF), 1, 0, 0, 0, 0); cycle();
    check("addi.SrcB", SrcB, 32'hFFFF_FFFF);
    drive(1, itype('h0D, 1, 2, 'hFFFF), 1, 0, 0, 0, 0); cycle();
    check("ori.SrcB", SrcB, 32'h0000_FFFF); check("ori.aluOpE", aluOpE, 5);
    drive(1, itype('h0F, 0, 2, 'h1234), 0, 0, 0, 0, 0); cycle();
    check("lui.aluOpE", aluOpE, 6); check("lui.SrcA", SrcA, 32'h1234_0000);

    // lw $8,0($1) then add $9,$8,$2: one bubble, then the add loads
    drive(1, itype('h23, 1, 8, 0), 32'h100, 0, 0, 0, 0); cycle();
    drive(1, rtype(8, 2, 9, 0, 'h20), 11, 22, 0, 0, 0); cycle();
    check("lu.bubble.validE", validE, 0);
    pcD = pcD - 32'd4;
    drive(1, rtype(8, 2, 9, 0, 'h20), 11, 22, 0, 0, 0); cycle();
    check("lu.add.validE", validE, 1); check("lu.add.writeRegE", writeRegE, 9);

    // load to $0 creates no hazard
    drive(1, itype('h23, 1, 0, 4), 32'h100, 0, 0, 0, 0); cycle();
    drive(1, rtype(0, 0, 9, 0, 'h20), 3, 4, 0, 0, 0); cycle();
    check("lu0.validE", validE, 1);

    // stall for 3 cycles with a new instruction presented, then flush under stall
    drive(1, rtype(1, 2, 6, 0, 'h24), 32'hF0F0, 32'h0FF0, 0, 0, 0); cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1, itype('h0E, 3, 7, 'h5A5A), 9, 9, 1, 0, 0); cycle();
      check("stall.readyD", readyD, 0); check("stall.SrcA", SrcA, 32'hF0F0);
    end
    drive(1, itype('h0E, 3, 7, 'h5A5A), 9, 9, 1, 1, 0); cycle();
    check("flush.validE", validE, 0);

    // illegal opcode, add to $0
    drive(1, itype('h3F, 1, 2, 3), 1, 2, 0, 0, 0); cycle();
    check("ill.illegalE", illegalE, 1); check("ill.regWriteE", regWriteE, 0);
    drive(1, rtype(1, 2, 0, 0, 'h20), 1, 2, 0, 0, 0); cycle();
    check("r0.regWriteE", regWriteE, 0);

    // reset with a valid instruction in E
    drive(1, rtype(1, 2, 3, 0, 'h20), 1, 2, 0, 0, 0); cycle();
    drive(1, itype('h23, 1, 8, 0), 1, 2, 1, 0, 1); cycle();
    check("rst.validE", validE, 0); check("rst.SrcA.lit", SrcA, 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive(($urandom % 8) != 0, rand_instr(), $urandom, $urandom,
            ($urandom % 7) == 0, ($urandom % 13) == 0, ($urandom % 61) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute stage: the producer side of the ALU operand interface.
- Decodes a MIPS instruction into an ALU opcode, selects and extends operands, and registers them for the execute stage on aluOpE/SrcA/SrcB.
- Owns the ID/EX pipeline register: stall, flush, bubble insertion, and load-use hazard detection.

Parameters:
- WORD_W, 32, datapath width (matches `WORD_WIDTH).
- OP_W, 4, ALU opcode width (matches `ALU_OP_LENGTH).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- validD  in  1  instrD holds a real instruction
- instrD  in  32  instruction word from decode
- pcD  in  32  PC of instrD
- rsDataD  in  32  register-file value of rs (already forwarded)
- rtDataD  in  32  register-file value of rt (already forwarded)
- stallE  in  1  hold the E register (downstream back-pressure)
- flushE  in  1  replace the E contents with a bubble
- readyD  out  1  decode may advance this cycle
- loadUseStall  out  1  load-use hazard detected (combinational)
- validE  out  1  E slot holds a real instruction
- aluOpE  out  OP_W  ALU opcode
- SrcA  out  32  ALU operand A (shift amount for shifts)
- SrcB  out  32  ALU operand B
- storeDataE  out  32  rt value for sw
- writeRegE  out  5  destination register
- regWriteE, memReadE, memWriteE, illegalE  out  1 each  control flags
- pcE  out  32  PC of the E instruction

Behaviour:
- ALU opcode encodings are fixed: AND=0, SUB=1, ADD=2, XOR=3, NOR=4, OR=5, EQB(pass SrcA)=6, SLT=7, SLTU=8, LS_LEFT=9, LS_RIGHT=10, AS_RIGHT=11.
- Shift operations shift SrcB by SrcA[4:0].
- R-type (op 0x00), decoded by funct:
  - 0x20/0x21 → ADD; 0x22/0x23 → SUB; 0x24 → AND; 0x25 → OR; 0x26 → XOR; 0x27 → NOR; 0x2A → SLT; 0x2B → SLTU.
  - SrcA=rsDataD, SrcB=rtDataD.
  - 0x00/0x02/0x03 (sll/srl/sra) → LS_LEFT/LS_RIGHT/AS_RIGHT with SrcA={27'b0,shamt}, SrcB=rtDataD.
  - 0x04/0x06/0x07 (sllv/srlv/srav) → same ops with SrcA=rsDataD.
  - Destination is rd.
- I-type:
  - 0x08/0x09 → ADD, sign-extended immediate.
  - 0x0A → SLT, sign-extended; 0x0B → SLTU, sign-extended.
  - 0x0C/0x0D/0x0E → AND/OR/XOR, zero-extended immediate.
  - For all of the above, SrcA=rsDataD, SrcB=immediate, destination rt.
  - 0x0F (lui) → EQB with SrcA={imm,16'b0}.
  - 0x23 (lw) → ADD, sign-extended, memReadE=1, destination rt.
  - 0x2B (sw) → ADD, sign-extended, memWriteE=1, regWriteE=0, storeDataE=rtDataD.
- Any other opcode/funct: aluOpE=ADD, regWriteE=0, memRead/memWrite=0, illegalE=1.
- regWriteE is forced to 0 when the destination is register 0.
- Operand usage for hazard checks:
  - rs is used by all except sll/srl/sra and lui.
  - rt is used by R-type and sw.
- loadUseStall = validD & validE & memReadE & (writeRegE != 0) & ((rsUsed & rs == writeRegE) | (rtUsed & rt == writeRegE)).
- Register update priority, evaluated each rising edge:
  1. rst → all outputs 0 (validE=0, aluOpE=0, SrcA=SrcB=0, pcE=0, all flags 0).
  2. flushE → bubble: validE=0, regWriteE=memReadE=memWriteE=illegalE=0; data fields don't-care, driven 0.
  3. stallE → hold every E field.
  4. loadUseStall → bubble as in flush; the D instruction is not consumed.
  5. Otherwise load the decoded D contents; validE=validD, and a bubble is loaded when validD=0.
- readyD = ~rst & ~stallE & ~loadUseStall. flushE does not lower readyD; a flushed D instruction is discarded by upstream.
- Latency: one cycle from D to E. With no stalls, throughput is one instruction per cycle.
- Load-use costs exactly one bubble. On the next cycle validE shows the bubble (memReadE=0), so the hazard clears and the dependent instruction advances.
- Reset asserted mid-stall or mid-hazard clears everything; there is no residual state.

Test Plan:
- add $3,$1,$2 with rs=5, rt=7, validD=1 → next cycle: aluOpE=2, SrcA=5, SrcB=7, writeRegE=3, regWriteE=1, validE=1.
- sra $4,$5,3 with rt=0x80000000 → aluOpE=11, SrcA=3, SrcB=0x80000000. srav with rs=0x23 → SrcA=0x23.
- Immediate extension:
  - addi imm=0xFFFF → SrcB=0xFFFFFFFF.
  - ori imm=0xFFFF → SrcB=0x0000FFFF, aluOpE=5.
  - lui imm=0x1234 → aluOpE=6, SrcA=0x12340000.
- lw $8,0($1) then add $9,$8,$2:
  - Cycle after the lw is loaded: loadUseStall=1, readyD=0.
  - Next edge: bubble in E (validE=0).
  - Following edge: the add loads.
  - A destination of $0 → no stall.
- stallE held 3 cycles with a new instrD → E fields unchanged and readyD=0. flushE with stallE=1 → validE=0 next cycle.
- Edge cases:
  - Unknown opcode 0x3F → illegalE=1, regWriteE=0.
  - add to $0 → regWriteE=0.
  - rst during validE=1 → all outputs 0 next edge.
